sequence_player: RTL and testbench

Plays the stored Simon Says pattern back to the player on the LEDs. It reads one 4-bit symbol per step from the sequence memory and lights it for a fixed on-time, then blanks the LEDs for a fixed gap. It signals completion so the game controller can hand the LEDs and switches over to the player's input-capture path. It is the display-side counterpart of the switch-capture block: that block turns switch flips into 4-bit symbols, and this block turns 4-bit symbols into LED flashes.

---
 rtl/sequence_player.sv | 140 ++++++++++++++
 tb/tb_sequence_player.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// Plays a stored 4-bit symbol sequence on the LEDs: each step is one fetch cycle, a lit phase and a dark gap.
// Optional abort input is enabled by defining PLAYER_ABORT_EN.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet, rd_addr = 0
//   FETCH | step index presented on rd_addr for one cycle
//   SHOW  | symbol lit for ON_CYCLES cycles
//   GAP   | LEDs dark for OFF_CYCLES cycles, then next step or DONE
//   DONE  | one cycle; produces the done pulse, returns to IDLE
module sequence_player #(
   parameter int ON_CYCLES  = 50,
   parameter int OFF_CYCLES = 20,
   parameter int MAX_LEN    = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [4:0]                 length,
   output logic [$clog2(MAX_LEN)-1:0] rd_addr,
   input  logic [3:0]                 rd_data,
   output logic [9:0]                 led,
   output logic                       busy,
   output logic                       done
`ifdef PLAYER_ABORT_EN
   ,
   input  logic                       abort
`endif
);

   localparam int AW   = $clog2(MAX_LEN);
   localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [4:0]    LEN_CAP = 5'(MAX_LEN);
   localparam logic [CW-1:0] CNT_ON  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] CNT_OFF = CW'(OFF_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] IDX_ONE = AW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SHOW  = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [AW-1:0] idx, idx_nx;
   logic [4:0]    len_q, len_nx;
   logic [9:0]    led_nx;
   logic          busy_nx, done_nx;
   logic          abort_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         len_q <= '0;
         led   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         len_q <= len_nx;
         led   <= led_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   // idx is held stable through FETCH/SHOW/GAP so the synchronous memory output stays valid
   assign rd_addr = idx;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      idx_nx    = idx;
      len_nx    = len_q;
      abort_hit = 1'b0;
      case (state)
         IDLE: begin
            // the done pulse appears in the first IDLE cycle; a start there still belongs to the DONE cycle
            if (start && !done) begin
               len_nx   = (length > LEN_CAP) ? LEN_CAP : length;
               idx_nx   = '0;
               state_nx = (len_nx == 5'd0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            state_nx = SHOW;
            cnt_nx   = CNT_ON;
         end
         SHOW: begin
            if (cnt == '0) begin
               state_nx = GAP;
               cnt_nx   = CNT_OFF;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               if (5'(idx) + 5'd1 == len_q) begin
                  state_nx = DONE;
                  idx_nx   = '0;
               end else begin
                  state_nx = FETCH;
                  idx_nx   = idx + IDX_ONE;
               end
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
`ifdef PLAYER_ABORT_EN
      if (abort && state != IDLE) begin
         state_nx  = IDLE;
         cnt_nx    = '0;
         idx_nx    = '0;
         abort_hit = 1'b1;
      end
`endif
   end

   always_comb begin
      busy_nx = !abort_hit && (state == FETCH || state == SHOW || state == GAP);
      done_nx = !abort_hit && (state == DONE);
      led_nx  = '0;
      if (!abort_hit && state == SHOW)
         led_nx = (cnt == CNT_ON) ? {6'b0, rd_data} : led;
   end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON=4, OFF=2, MAX_LEN=16 and a synchronous-read symbol memory.
// Abort scenarios are exercised only when PLAYER_ABORT_EN is defined.
module tb_sequence_player;
   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int STEP = 1 + ON + OFF;

   logic       clk;
   logic       reset;
   logic       start;
   logic [4:0] length;
   logic [3:0] rd_addr;
   logic [3:0] rd_data;
   logic [9:0] led;
   logic       busy;
   logic       done;
`ifdef PLAYER_ABORT_EN
   logic       abort;
`endif

   int errors = 0;
   int checks = 0;

   logic [3:0] mem [16];

   sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_LEN(16)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .length(length),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .led(led),
      .busy(busy),
      .done(done)
`ifdef PLAYER_ABORT_EN
      ,
      .abort(abort)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives start for edge k, then samples every cycle t = 0..ncyc-1 after edge k+t.
   // With restart set, start is pulsed again mid-SHOW of step 0 and during the done cycle.
   task automatic run_seq(input logic [4:0] ln, input int ncyc, input bit restart);
      int n;
      int s;
      int r;
      logic [9:0] led_e;
      n = (ln > 5'd16) ? 16 : int'(ln);
      length = ln;
      start  = 1'b1;
      tick();
      length = 5'd7;
      for (int t = 0; t < ncyc; t++) begin
         led_e = '0;
         if (n > 0 && t >= 2 && t <= STEP * n) begin
            s = (t - 2) / STEP;
            r = (t - 2) % STEP;
            if (r < ON) led_e = {6'b0, mem[s]};
         end
         check($sformatf("busy len=%0d t=%0d", ln, t), 16'(busy), 16'((n > 0) && t >= 1 && t <= STEP * n));
         check($sformatf("done len=%0d t=%0d", ln, t), 16'(done), 16'(t == STEP * n + 1));
         check($sformatf("led len=%0d t=%0d", ln, t), 16'(led), 16'(led_e));
         if (n > 0 && t < STEP * n && (t % STEP) == 0)
            check($sformatf("rd_addr fetch len=%0d t=%0d", ln, t), 16'(rd_addr), 16'(t / STEP));
         if (t >= STEP * n)
            check($sformatf("rd_addr idle len=%0d t=%0d", ln, t), 16'(rd_addr), 16'(0));
         start = restart && (t == 3 || t == STEP * n + 1);
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] init_vals [16];
      init_vals = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h8, 4'h3, 4'h5, 4'h9,
                    4'hF, 4'hA, 4'h6, 4'hC, 4'h7, 4'hE, 4'hB, 4'hD};
      for (int i = 0; i < 16; i++) mem[i] = init_vals[i];
      reset  = 1'b0;
      start  = 1'b0;
      length = 5'd0;
`ifdef PLAYER_ABORT_EN
      abort  = 1'b0;
`endif
      tick();
      tick();
      check("reset led", 16'(led), 16'(0));
      check("reset busy", 16'(busy), 16'(0));
      check("reset done", 16'(done), 16'(0));
      check("reset rd_addr", 16'(rd_addr), 16'(0));
      @(negedge clk);
      reset = 1'b1;
      tick();

      // three-symbol pattern, length changed after acceptance
      run_seq(5'd3, 27, 1'b0);
      // same pattern with extra start pulses mid-SHOW and in the done cycle
      run_seq(5'd3, 30, 1'b1);
      // empty sequence
      run_seq(5'd0, 5, 1'b0);
      // over-long request clamps to MAX_LEN, includes a zero symbol at step 3
      run_seq(5'd20, 16 * STEP + 4, 1'b0);

      // reset in the middle of step 2
      length = 5'd5;
      start  = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 17; t++) tick();
      check("pre-reset led step2", 16'(led), 16'({6'b0, mem[2]}));
      #2;
      reset = 1'b0;
      #1;
      check("async reset led", 16'(led), 16'(0));
      check("async reset busy", 16'(busy), 16'(0));
      check("async reset done", 16'(done), 16'(0));
      check("async reset rd_addr", 16'(rd_addr), 16'(0));
      tick();
      @(negedge clk);
      reset = 1'b1;
      for (int t = 0; t < 8; t++) begin
         tick();
         check($sformatf("post-reset quiet done t=%0d", t), 16'(done), 16'(0));
         check($sformatf("post-reset quiet busy t=%0d", t), 16'(busy), 16'(0));
      end
      run_seq(5'd2, 18, 1'b0);

`ifdef PLAYER_ABORT_EN
      // abort during GAP of step 1
      length = 5'd4;
      start  = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 12; t++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort busy", 16'(busy), 16'(0));
      check("abort led", 16'(led), 16'(0));
      for (int t = 0; t < 30; t++) begin
         check($sformatf("abort no done t=%0d", t), 16'(done), 16'(0));
         tick();
      end
      // abort while idle together with start: start accepted
      abort = 1'b1;
      length = 5'd1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      tick();
      check("abort idle start busy", 16'(busy), 16'(1));
      for (int t = 0; t < STEP + 4; t++) tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout reached observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
